// File: rtl/btn_cmd_ctrl_pkg.sv
// Shared definitions for the button command path: FSM encodings, command ids
// and the fixed-priority encoder used for grants.
package btn_cmd_ctrl_pkg;

  localparam int BTN_N = 4;
  localparam int ID_W  = 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PEND     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF  = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  // Command indices shared with the game FSM.
  localparam logic [ID_W-1:0] CMD_HIT   = 2'd0;
  localparam logic [ID_W-1:0] CMD_STAND = 2'd1;
  localparam logic [ID_W-1:0] CMD_DEAL  = 2'd2;
  localparam logic [ID_W-1:0] CMD_NEW   = 2'd3;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [ID_W-1:0] prio_idx(input logic [BTN_N-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = BTN_N - 1; i >= 0; i--)
      if (v[i]) idx = ID_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/btn_cmd_ctrl_holdoff_timer.sv
// One-shot down-counter: load arms it with CYCLES-1, done is high during the
// last counted cycle so the owner can leave on the following edge.
module holdoff_timer #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam logic [31:0] LOAD_VAL = 32'(CYCLES - 1);

  logic [31:0] r_cnt;
  logic        r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load) begin
      r_cnt <= LOAD_VAL;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 32'd1;
    end
  end

  assign done = r_run && (r_cnt == '0);

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Turns debounced button levels into one arbitrated command on a valid/ready
// handshake, then locks out input for a hold-off and until all are released.
module btn_cmd_ctrl
  import btn_cmd_ctrl_pkg::*;
#(
  parameter int CLOCK_FREQ  = 100000000,
  parameter int HOLDOFF_DIV = 10,
  parameter int NUM_BTN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [ID_W-1:0]    cmd_id,
  output logic [NUM_BTN-1:0] cmd_onehot,
  output logic               busy,
  output logic               dropped
);
  localparam int HOLD_CYC = CLOCK_FREQ / HOLDOFF_DIV;

  logic [1:0]         r_state;
  logic [NUM_BTN-1:0] r_btn_q;
  logic               r_cmd_valid;
  logic [ID_W-1:0]    r_cmd_id;
  logic [NUM_BTN-1:0] r_cmd_onehot;
  logic               r_dropped;

  logic [1:0]         w_state_nxt;
  logic [NUM_BTN-1:0] w_rise;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_BTN-1:0] w_grant_oh;
  logic               w_grant;
  logic               w_hs;
  logic               w_load;
  logic               w_done;
  logic               w_drop;

  assign w_rise     = btn_i & ~r_btn_q;
  assign w_grant_id = prio_idx(w_rise);
  assign w_grant_oh = NUM_BTN'(1) << w_grant_id;
  assign w_grant    = (r_state == ST_IDLE) && (|w_rise);
  assign w_hs       = (r_state == ST_PEND) && r_cmd_valid && cmd_ready;
  assign w_load     = w_hs;

  holdoff_timer #(.CYCLES(HOLD_CYC)) u_holdoff (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .done (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_drop      = |w_rise;
    case (r_state)
      ST_IDLE: begin
        // Only the granted edge is exempt; everything else is lost.
        w_drop = |(w_rise & ~w_grant_oh);
        if (|w_rise) w_state_nxt = ST_PEND;
      end
      ST_PEND:     if (w_hs) w_state_nxt = ST_HOLDOFF;
      ST_HOLDOFF:  if (w_done) w_state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: if (btn_i == '0) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_btn_q      <= '1;
      r_cmd_valid  <= 1'b0;
      r_cmd_id     <= '0;
      r_cmd_onehot <= '0;
      r_dropped    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_btn_q   <= btn_i;
      r_dropped <= w_drop;
      if (w_grant) begin
        r_cmd_valid  <= 1'b1;
        r_cmd_id     <= w_grant_id;
        r_cmd_onehot <= w_grant_oh;
      end else if (w_hs) begin
        r_cmd_valid  <= 1'b0;
        r_cmd_onehot <= '0;
      end
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_id     = r_cmd_id;
  assign cmd_onehot = r_cmd_onehot;
  assign dropped    = r_dropped;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Directed bench for btn_cmd_ctrl with a 10-cycle hold-off.
module tb_btn_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_i = 4'b0000;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] cmd_onehot;
  logic       busy;
  logic       dropped;

  int errors = 0;
  int checks = 0;

  btn_cmd_ctrl #(.CLOCK_FREQ(1000), .HOLDOFF_DIV(100), .NUM_BTN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (btn_i),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_id     (cmd_id),
    .cmd_onehot (cmd_onehot),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    btn_i = 4'b0000;
    cmd_ready = 1'b0;
    tick(15);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({cmd_valid, cmd_id, cmd_onehot, busy, dropped} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000000", {cmd_valid, cmd_id, cmd_onehot, busy, dropped});
    end
    rst = 1'b0;
    tick(2);
    checks++;
    if ({cmd_valid, busy, dropped} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b want 000", {cmd_valid, busy, dropped});
    end
  endtask

  task automatic test_single_press();
    btn_i = 4'b0100;
    tick();
    checks++;
    if ({cmd_valid, cmd_id, cmd_onehot, busy, dropped} !== {1'b1, 2'd2, 4'b0100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_grant: got %b want 110010010", {cmd_valid, cmd_id, cmd_onehot, busy, dropped});
    end
    tick(3);
    checks++;
    if ({cmd_valid, cmd_id, cmd_onehot} !== {1'b1, 2'd2, 4'b0100}) begin
      errors++;
      $display("FAIL single_hold: got %b want 1100100", {cmd_valid, cmd_id, cmd_onehot});
    end
    btn_i = 4'b0000;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if ({cmd_valid, cmd_onehot, busy} !== {1'b0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL single_handshake: got %b want 000001", {cmd_valid, cmd_onehot, busy});
    end
    tick(9);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_m9: got %b want 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_wait_rel: got %b want 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_exit: got %b want 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    btn_i = 4'b1010;
    tick();
    checks++;
    if ({cmd_valid, cmd_id, cmd_onehot, dropped} !== {1'b1, 2'd1, 4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL simul_grant: got %b want 10100101", {cmd_valid, cmd_id, cmd_onehot, dropped});
    end
    tick();
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL simul_drop_pulse: got %b want 0", dropped);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    settle();
  endtask

  task automatic test_holdoff_release();
    int bad;
    btn_i = 4'b0001;
    tick();
    checks++;
    if ({cmd_valid, cmd_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL hr_grant: got %b want 100", {cmd_valid, cmd_id});
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 29; i++) begin
      if (busy !== 1'b1 || cmd_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL hr_locked: got bad=%0d busy=%b valid=%b want bad=0 busy=1 valid=0", bad, busy, cmd_valid);
    end
    btn_i = 4'b0000;
    tick();
    checks++;
    if ({busy, cmd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL hr_release: got %b want 00", {busy, cmd_valid});
    end
    tick();
    btn_i = 4'b0010;
    tick();
    checks++;
    if ({cmd_valid, cmd_id} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL hr_new_press: got %b want 101", {cmd_valid, cmd_id});
    end
    cmd_ready = 1'b1;
    tick();
    settle();
  endtask

  task automatic test_held_reset();
    rst = 1'b1;
    btn_i = 4'b1000;
    tick(2);
    rst = 1'b0;
    tick(5);
    checks++;
    if ({cmd_valid, busy, dropped} !== 3'b000) begin
      errors++;
      $display("FAIL held_no_cmd: got %b want 000", {cmd_valid, busy, dropped});
    end
    btn_i = 4'b0000;
    tick();
    btn_i = 4'b1000;
    tick();
    checks++;
    if ({cmd_valid, cmd_id, cmd_onehot} !== {1'b1, 2'd3, 4'b1000}) begin
      errors++;
      $display("FAIL held_repress: got %b want 1111000", {cmd_valid, cmd_id, cmd_onehot});
    end
    cmd_ready = 1'b1;
    tick();
    settle();
  endtask

  task automatic test_reset_mid();
    btn_i = 4'b0100;
    tick();
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pend: got %b want 1", cmd_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_valid, cmd_onehot, busy} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got %b want 000000", {cmd_valid, cmd_onehot, busy});
    end
    tick();
    btn_i = 4'b0000;
    rst = 1'b0;
    tick(2);
    checks++;
    if ({cmd_valid, busy, cmd_id} !== 4'b0) begin
      errors++;
      $display("FAIL mid_after_release: got %b want 0000", {cmd_valid, busy, cmd_id});
    end
  endtask

  task automatic test_perm_ready();
    int vcount;
    cmd_ready = 1'b1;
    btn_i = 4'b0001;
    tick();
    checks++;
    if ({cmd_valid, cmd_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL pr_grant: got %b want 100", {cmd_valid, cmd_id});
    end
    tick();
    checks++;
    if ({cmd_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL pr_one_cycle: got %b want 01", {cmd_valid, busy});
    end
    btn_i = 4'b1000;
    tick();
    checks++;
    if (dropped !== 1'b1) begin
      errors++;
      $display("FAIL pr_dropped: got %b want 1", dropped);
    end
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cmd_valid === 1'b1) vcount++;
    end
    btn_i = 4'b0000;
    tick();
    checks++;
    if (vcount != 0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL pr_never_issued: got vcount=%0d busy=%b valid=%b want 0 0 0", vcount, busy, cmd_valid);
    end
    tick(2);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL pr_ready_idle: got %b want 0", cmd_valid);
    end
    cmd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_holdoff_release();
    test_held_reset();
    test_reset_mid();
    test_perm_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
